// File: rtl/contador_monitor.sv
// Watches an up/down counter and flags illegal steps, legal wraps and compare matches.
// All outputs are registered, so a sample taken at a clock edge shows up after that edge.
module contador_monitor #(
    parameter int WIDTH      = 8,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      cont_in,
    input  logic                  updown,
    input  logic                  sample_en,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      cmp_val,
    output logic                  match,
    output logic                  tc,
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output logic                  step_err,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_TRACK = 2'b01,
        S_FAULT = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] MAX = '1;

    state_t           st;
    logic [WIDTH-1:0] prev_cont;
    logic             prev_dir;
    logic [WIDTH-1:0] exp_cont;
    logic             legal;
    logic             wrap;

    assign exp_cont = prev_dir ? prev_cont + 1'b1 : prev_cont - 1'b1;
    assign legal    = (cont_in == exp_cont);
    // Only a legal step can wrap; the endpoint test picks out the terminal transition.
    assign wrap     = legal && ((prev_dir && prev_cont == MAX) || (!prev_dir && prev_cont == '0));
    assign state    = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= S_INIT;
            prev_cont <= '0;
            prev_dir  <= 1'b0;
            match     <= 1'b0;
            tc        <= 1'b0;
            wrap_cnt  <= '0;
            step_err  <= 1'b0;
            err_cnt   <= '0;
        end else if (clear) begin
            st       <= S_INIT;
            match    <= 1'b0;
            tc       <= 1'b0;
            wrap_cnt <= '0;
            step_err <= 1'b0;
            err_cnt  <= '0;
        end else if (sample_en) begin
            match     <= (cont_in == cmp_val);
            tc        <= 1'b0;
            // Always re-baseline, even on error, so one glitch yields one error.
            prev_cont <= cont_in;
            prev_dir  <= updown;
            case (st)
                S_INIT: st <= S_TRACK;
                S_TRACK, S_FAULT: begin
                    if (legal) begin
                        if (wrap) begin
                            tc <= 1'b1;
                            if (wrap_cnt != '1) wrap_cnt <= wrap_cnt + 1'b1;
                        end
                    end else begin
                        step_err <= 1'b1;
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        st <= S_FAULT;
                    end
                end
                default: st <= S_INIT;
            endcase
        end else begin
            match <= 1'b0;
            tc    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_monitor.sv
// Directed bench for contador_monitor: a reference model pushes expected outputs
// when a sample is driven, and they are popped and checked after the clock edge.
module tb_contador_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cont_in;
    logic        updown;
    logic        sample_en;
    logic        clear;
    logic [7:0]  cmp_val;
    logic        match;
    logic        tc;
    logic [15:0] wrap_cnt;
    logic        step_err;
    logic [7:0]  err_cnt;
    logic [1:0]  state;

    contador_monitor dut (
        .clk(clk), .reset(reset), .cont_in(cont_in), .updown(updown),
        .sample_en(sample_en), .clear(clear), .cmp_val(cmp_val),
        .match(match), .tc(tc), .wrap_cnt(wrap_cnt), .step_err(step_err),
        .err_cnt(err_cnt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        match;
        logic        tc;
        logic [15:0] wrap_cnt;
        logic        step_err;
        logic [7:0]  err_cnt;
        logic [1:0]  state;
    } exp_t;

    exp_t q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int tc_seen  = 0;
    int match_seen = 0;

    // reference model state
    logic [7:0]  m_prev;
    logic        m_dir;
    logic [1:0]  m_st;
    logic [15:0] m_wrap;
    logic        m_se;
    logic [7:0]  m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_dir = 1'b0; m_st = 2'b00;
        m_wrap = '0; m_se = 1'b0; m_err = '0;
    endtask

    task automatic step(input logic [7:0] v, input logic d, input logic en, input logic clr);
        exp_t        e;
        exp_t        got;
        logic [7:0]  nxt;
        @(negedge clk);
        cont_in = v; updown = d; sample_en = en; clear = clr;
        e.match = 1'b0; e.tc = 1'b0;
        if (clr) begin
            m_st = 2'b00; m_wrap = '0; m_se = 1'b0; m_err = '0;
        end else if (en) begin
            e.match = (v == cmp_val);
            if (m_st == 2'b00) begin
                m_st = 2'b01;
            end else begin
                nxt = m_dir ? m_prev + 8'd1 : m_prev - 8'd1;
                if (v != nxt) begin
                    m_se = 1'b1;
                    if (m_err != 8'hff) m_err++;
                    m_st = 2'b10;
                end else if ((m_dir && v == 8'h00) || (!m_dir && v == 8'hff)) begin
                    e.tc = 1'b1;
                    if (m_wrap != 16'hffff) m_wrap++;
                end
            end
            m_prev = v; m_dir = d;
        end
        e.wrap_cnt = m_wrap; e.step_err = m_se; e.err_cnt = m_err; e.state = m_st;
        q.push_back(e);
        @(posedge clk); #1;
        got = q.pop_front();
        chk("match",    {31'd0, match},    {31'd0, got.match});
        chk("tc",       {31'd0, tc},       {31'd0, got.tc});
        chk("wrap_cnt", {16'd0, wrap_cnt}, {16'd0, got.wrap_cnt});
        chk("step_err", {31'd0, step_err}, {31'd0, got.step_err});
        chk("err_cnt",  {24'd0, err_cnt},  {24'd0, got.err_cnt});
        chk("state",    {30'd0, state},    {30'd0, got.state});
        if (tc) tc_seen++;
        if (match) match_seen++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_match"},    {31'd0, match},    0);
        chk({tag, "_tc"},       {31'd0, tc},       0);
        chk({tag, "_wrap_cnt"}, {16'd0, wrap_cnt}, 0);
        chk({tag, "_step_err"}, {31'd0, step_err}, 0);
        chk({tag, "_err_cnt"},  {24'd0, err_cnt},  0);
        chk({tag, "_state"},    {30'd0, state},    0);
    endtask

    initial begin
        // T1: held in reset with random inputs
        reset = 1'b0; clear = 1'b0; sample_en = 1'b0; cont_in = '0; updown = 1'b0; cmp_val = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cont_in = 8'($urandom); updown = 1'($urandom); sample_en = 1'($urandom);
            clear = 1'($urandom); cmp_val = 8'($urandom);
            @(posedge clk); #1;
            chk_all_zero("t1");
        end
        @(negedge clk);
        reset = 1'b1; clear = 1'b0; sample_en = 1'b0; cmp_val = 8'd100;
        model_reset();

        // T2: full up count 0..255..0
        tc_seen = 0;
        for (int i = 0; i <= 256; i++) step(8'(i), 1'b1, 1'b1, 1'b0);
        chk("t2_tc_count", tc_seen, 1);
        chk("t2_wrap_cnt", {16'd0, wrap_cnt}, 1);
        chk("t2_err_cnt",  {24'd0, err_cnt}, 0);

        // T3: down count across zero
        step(8'd0, 1'b0, 1'b1, 1'b1);
        tc_seen = 0;
        step(8'd0,   1'b0, 1'b1, 1'b0);
        step(8'd255, 1'b0, 1'b1, 1'b0);
        chk("t3_tc_after_255", {31'd0, tc}, 1);
        step(8'd254, 1'b0, 1'b1, 1'b0);
        chk("t3_tc_count", tc_seen, 1);
        chk("t3_step_err", {31'd0, step_err}, 0);

        // T4: skipped value
        step(8'd0, 1'b0, 1'b1, 1'b1);
        step(8'd10, 1'b1, 1'b1, 1'b0);
        step(8'd11, 1'b1, 1'b1, 1'b0);
        step(8'd13, 1'b1, 1'b1, 1'b0);
        chk("t4_step_err", {31'd0, step_err}, 1);
        chk("t4_state",    {30'd0, state}, 2);
        step(8'd14, 1'b1, 1'b1, 1'b0);
        chk("t4_err_cnt",  {24'd0, err_cnt}, 1);

        // T5: compare match
        step(8'd0, 1'b0, 1'b1, 1'b1);
        match_seen = 0;
        for (int i = 95; i <= 105; i++) step(8'(i), 1'b1, 1'b1, 1'b0);
        chk("t5_match_count", match_seen, 1);

        // gap holds baseline, then direction flip takes effect one step later
        step(8'd0,   1'b1, 1'b0, 1'b0);
        step(8'd200, 1'b0, 1'b0, 1'b0);
        step(8'd106, 1'b1, 1'b1, 1'b0);
        step(8'd107, 1'b0, 1'b1, 1'b0);
        step(8'd106, 1'b0, 1'b1, 1'b0);
        chk("flip_no_err", {31'd0, step_err}, 0);

        // T6: clear with simultaneous sample mid-count
        step(8'd50, 1'b1, 1'b1, 1'b0);
        step(8'd60, 1'b1, 1'b1, 1'b0);
        step(8'd53, 1'b1, 1'b1, 1'b1);
        chk("t6_state", {30'd0, state}, 0);
        chk("t6_err",   {24'd0, err_cnt}, 0);
        step(8'd99, 1'b1, 1'b1, 1'b0);
        chk("t6_rebase_err", {31'd0, step_err}, 0);
        step(8'd100, 1'b1, 1'b1, 1'b0);

        // err_cnt saturation: every step illegal
        for (int i = 0; i < 270; i++) step((i % 2) ? 8'd128 : 8'd7, 1'b1, 1'b1, 1'b0);
        chk("sat_err_cnt", {24'd0, err_cnt}, 255);
        chk("sat_step_err", {31'd0, step_err}, 1);

        // asynchronous reset away from the clock edge
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
